// File: rtl/sha256_compress_ctrl_if.sv
// Block/digest bus of the SHA-256 compression controller.
// A block transfers on a rising edge where blk_valid and blk_ready are both high.
// The producer must hold blk_valid and blk_data until that edge. The digest side
// has no ready: digest_valid is a one-cycle pulse, and digest holds until the next pulse.
interface sha256_compress_ctrl_if;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic [255:0] digest;
  logic         digest_valid;
  logic         busy;
  logic [1:0]   fsm_state;

  modport master (
    output blk_valid, blk_data, blk_first,
    input  blk_ready, digest, digest_valid, busy, fsm_state
  );

  modport slave (
    input  blk_valid, blk_data, blk_first,
    output blk_ready, digest, digest_valid, busy, fsm_state
  );
endinterface

// File: rtl/sha256_compress_ctrl.sv
// SHA-256 compression controller: this block runs the 64 rounds of one 512-bit block.
// It computes RND_PER_CLK rounds per clock and then adds the result into the chaining hash.
module sha256_compress_ctrl #(
  parameter int RND_PER_CLK = 1
) (
  input logic                   clk,
  input logic                   rst,
  sha256_compress_ctrl_if.slave bus
);
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, FINAL = 2'd2} state_t;

  generate
    if (RND_PER_CLK != 1 && RND_PER_CLK != 2) begin : g_bad_rnd_per_clk
      $error("RND_PER_CLK must be 1 or 2");
    end
  endgenerate

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t ssig0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t ssig1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // One SHA-256 round. The working variables are packed as {a,b,c,d,e,f,g,h}, with a in the top word.
  function automatic logic [255:0] sha256_round(input logic [255:0] v, input word_t k, input word_t w);
    word_t a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = v;
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  state_t       state_q, state_d;
  logic [255:0] wv_q, h_q, digest_q;
  word_t        w_q [16];
  logic [5:0]   rnd_q, rnd_p1;
  logic         digest_valid_q;
  logic [255:0] rnd1, rnd2, h_sum;
  word_t        new1, new2;
  logic         last_rnd;

  assign rnd_p1   = rnd_q + 6'd1;
  assign last_rnd = (rnd_q == 6'(64 - RND_PER_CLK));

  always_comb begin
    rnd1 = sha256_round(wv_q, K[rnd_q], w_q[0]);
    rnd2 = sha256_round(rnd1, K[rnd_p1], w_q[1]);
    new1 = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
    // The second new word uses the schedule after it has shifted by one word.
    new2 = ssig1(w_q[15]) + w_q[10] + ssig0(w_q[2]) + w_q[1];
    for (int i = 0; i < 8; i++) begin
      h_sum[32*i +: 32] = h_q[32*i +: 32] + wv_q[32*i +: 32];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.blk_valid) state_d = ROUND;
      ROUND:   if (last_rnd)      state_d = FINAL;
      FINAL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wv_q           <= '0;
      h_q            <= '0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
      rnd_q          <= '0;
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
    end else begin
      digest_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.blk_valid) begin
          for (int i = 0; i < 16; i++) w_q[i] <= bus.blk_data[511 - 32*i -: 32];
          wv_q  <= bus.blk_first ? IV : h_q;
          if (bus.blk_first) h_q <= IV;
          rnd_q <= '0;
        end
        ROUND: begin
          rnd_q <= rnd_q + 6'(RND_PER_CLK);
          if (RND_PER_CLK == 2) begin
            wv_q <= rnd2;
            for (int i = 0; i < 14; i++) w_q[i] <= w_q[i + 2];
            w_q[14] <= new1;
            w_q[15] <= new2;
          end else begin
            wv_q <= rnd1;
            for (int i = 0; i < 15; i++) w_q[i] <= w_q[i + 1];
            w_q[15] <= new1;
          end
        end
        FINAL: begin
          h_q            <= h_sum;
          digest_q       <= h_sum;
          digest_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.blk_ready    = (state_q == IDLE);
  assign bus.busy         = (state_q == ROUND) || (state_q == FINAL);
  assign bus.digest       = digest_q;
  assign bus.digest_valid = digest_valid_q;
  assign bus.fsm_state    = state_q;
endmodule

// File: tb/tb_sha256_compress_ctrl.sv
// Directed bench for sha256_compress_ctrl. It uses known FIPS 180-4 digests
// and exercises one instance with one round per clock and one with two.
module tb_sha256_compress_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sha256_compress_ctrl_if bus1 ();
  sha256_compress_ctrl_if bus2 ();

  sha256_compress_ctrl #(.RND_PER_CLK(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  sha256_compress_ctrl #(.RND_PER_CLK(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  logic         drv_valid, drv_first;
  logic [511:0] drv_data;
  int           sel;

  assign bus1.blk_valid = drv_valid && (sel == 0);
  assign bus1.blk_data  = drv_data;
  assign bus1.blk_first = drv_first;
  assign bus2.blk_valid = drv_valid && (sel == 1);
  assign bus2.blk_data  = drv_data;
  assign bus2.blk_first = drv_first;

  logic         obs_ready, obs_dvalid, obs_busy;
  logic [1:0]   obs_state;
  logic [255:0] obs_digest;
  assign obs_ready  = (sel == 1) ? bus2.blk_ready    : bus1.blk_ready;
  assign obs_dvalid = (sel == 1) ? bus2.digest_valid : bus1.digest_valid;
  assign obs_busy   = (sel == 1) ? bus2.busy         : bus1.busy;
  assign obs_state  = (sel == 1) ? bus2.fsm_state    : bus1.fsm_state;
  assign obs_digest = (sel == 1) ? bus2.digest       : bus1.digest;

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_TWO1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_TWO2  = {448'h0, 64'd448};
  localparam logic [255:0] DIG_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] DIG_TWO1  = 256'h85e655d6_417a1795_3363376a_624cde5c_76e09589_cac5f811_cc4b32c1_f20e533a;
  localparam logic [255:0] DIG_TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Waits a bounded time for blk_ready, then presents the block for one accept edge.
  task automatic start_block(input logic [511:0] d, input logic first, input string tag);
    int n = 0;
    while (!obs_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_ready"}, obs_ready, 1);
    drv_data  = d;
    drv_first = first;
    drv_valid = 1'b1;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    check({tag, "_busy"}, obs_busy, 1);
  endtask

  // Counts edges from the accept edge until the digest pulse.
  // When toggle is 1, it keeps a changing block offered the whole time.
  task automatic wait_digest(input logic [255:0] exp, input string tag, input bit toggle);
    int n = 0;
    int exp_lat = (sel == 1) ? 33 : 65;
    do begin
      if (toggle) begin
        for (int i = 0; i < 16; i++) drv_data[32*i +: 32] = $urandom;
        drv_valid = 1'b1;
      end
      @(posedge clk); #1;
      n++;
      if (toggle && n == 10) check({tag, "_ready_low"}, obs_ready, 0);
    end while (!obs_dvalid && n < 200);
    drv_valid = 1'b0;
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_digest"}, obs_digest, exp);
    check({tag, "_ready_back"}, obs_ready, 1);
    check({tag, "_busy_low"}, obs_busy, 0);
  endtask

  task automatic check_pulse_end(input logic [255:0] exp, input string tag);
    @(posedge clk); #1;
    check({tag, "_pulse_end"}, obs_dvalid, 0);
    check({tag, "_held"}, obs_digest, exp);
    check({tag, "_idle"}, obs_busy, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    drv_valid = 1'b0;
    drv_first = 1'b0;
    drv_data  = '0;
    sel       = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      check("rst_digest", obs_digest, 0);
      check("rst_dvalid", obs_dvalid, 0);
      check("rst_busy", obs_busy, 0);
      check("rst_ready", obs_ready, 1);
      check("rst_state", obs_state, 0);
    end
    sel = 0;
    @(negedge clk);
    rst = 1'b0;

    for (int s = 0; s < 2; s++) begin
      sel = s;
      start_block(BLK_ABC, 1'b1, "abc");
      wait_digest(DIG_ABC, "abc", 1'b0);
      check_pulse_end(DIG_ABC, "abc");

      start_block(BLK_EMPTY, 1'b1, "empty");
      wait_digest(DIG_EMPTY, "empty", 1'b0);

      // The second block is offered in the digest cycle, so it is accepted at the earliest edge.
      start_block(BLK_TWO1, 1'b1, "two_b1");
      wait_digest(DIG_TWO1, "two_b1", 1'b0);
      start_block(BLK_TWO2, 1'b0, "two_b2");
      wait_digest(DIG_TWO, "two_b2", 1'b0);
      check_pulse_end(DIG_TWO, "two");
    end

    sel = 0;
    start_block(BLK_ABC, 1'b1, "hold");
    wait_digest(DIG_ABC, "hold", 1'b1);
    check_pulse_end(DIG_ABC, "hold");

    start_block(BLK_ABC, 1'b1, "rep1");
    wait_digest(DIG_ABC, "rep1", 1'b0);
    start_block(BLK_ABC, 1'b1, "rep2");
    wait_digest(DIG_ABC, "rep2", 1'b0);

    start_block(BLK_EMPTY, 1'b1, "abort");
    repeat (29) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("abort_digest", obs_digest, 0);
    check("abort_dvalid", obs_dvalid, 0);
    check("abort_ready", obs_ready, 1);
    check("abort_state", obs_state, 0);
    @(negedge clk);
    rst = 1'b0;
    start_block(BLK_ABC, 1'b1, "post_rst");
    wait_digest(DIG_ABC, "post_rst", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sha256_compress_ctrl.md
Name: sha256_compress_ctrl

Overview:
- Sequences the combinational SHA-256 round datapath (sha256_round) over the 64 rounds of one 512-bit message block.
- Owns the working-variable registers, the 16-word message-schedule shift register, the K constant ROM, the chaining hash H0..H7 and the final feed-forward addition.
- Sits between the image-key padding/feeder logic and the chaos-parameter derivation logic, exchanging blocks and digests via valid/ready handshakes.

Parameters:
- RND_PER_CLK, 1, rounds per clock: 1 or 2. With 2, two sha256_round instances are chained combinationally and the schedule advances 2 words per clock. Any other value is a elaboration error.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- blk_valid  in  1  blk_data/blk_first are valid.
- blk_ready  out  1  the block can accept a message block (high only in IDLE).
- blk_data  in  512  message block, big-endian; W0 = blk_data[511:480], W15 = blk_data[31:0].
- blk_first  in  1  first block of a message: chain starts from the FIPS 180-4 IV, not the current H.
- digest  out  256  H0..H7; H0 = digest[255:224].
- digest_valid  out  1  one-cycle pulse: digest has been updated with the just-finished block.
- busy  out  1  high in ROUND and FINAL.

Behaviour:
- Reset (async, immediate):
  - State = IDLE; round counter = 0.
  - digest = 0; digest_valid = 0; busy = 0; blk_ready = 1 after reset deasserts.
  - W and working registers = 0.
- States:
  - IDLE -> ROUND on blk_valid & blk_ready.
  - ROUND -> FINAL when the last round executes.
  - FINAL -> IDLE unconditionally.
- Accept edge (IDLE, blk_valid & blk_ready):
  - W[0..15] loaded from blk_data.
  - a..h loaded from the IV if blk_first = 1, else from the current H.
  - If blk_first = 1, H is also loaded with the IV on the same edge.
  - rnd = 0.
- ROUND, each edge:
  - Apply RND_PER_CLK rounds: a..h <= round outputs, using K[rnd] and W[0] (and K[rnd+1], W[1] for the second instance).
  - The W shift register shifts by RND_PER_CLK.
  - Each appended word = sigma1(W[14]) + W[9] + sigma0(W[1]) + W[0], mod 2^32, where:
    - sigma0 = rotr7 ^ rotr18 ^ shr3;
    - sigma1 = rotr17 ^ rotr19 ^ shr10.
  - For RND_PER_CLK = 2, the second appended word uses the shifted-by-one view.
  - rnd += RND_PER_CLK.
  - Leave ROUND on the edge that executes round 63.
- FINAL edge: Hi <= Hi + working var i, each mod 2^32 (32-bit wrap, no carry between words). digest reflects the new H and digest_valid = 1 for exactly this cycle.
- Latency:
  - Accept edge at cycle t; digest_valid high in cycle t + 64/RND_PER_CLK + 1.
  - blk_ready returns the same cycle digest_valid is high.
  - The next block may be accepted on the edge that ends the digest_valid cycle.
  - Throughput: one block per 64/RND_PER_CLK + 2 cycles.
- K ROM: 64 FIPS 180-4 constants, combinational, indexed by rnd.
- Handshake rules:
  - blk_valid while busy is ignored; no buffering, and the upstream block must hold its data.
  - blk_data is sampled only on the accept edge; changes afterwards have no effect.
- digest holds its value between pulses and is never partially updated mid-block.
- Reset mid-block aborts the block and clears H. A non-first block after reset chains from H = 0, which is legal but the upstream block must use blk_first.
- There is no downstream back-pressure: consumers must capture digest on digest_valid or read the held value before the next FINAL.

Test Plan:
- Single block "abc" (0x61626380, 0 x14, 0x00000018), blk_first = 1 -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, pulse at t+65 (RND_PER_CLK = 1) and t+33 (RND_PER_CLK = 2).
- Empty message (0x80000000, zeros, length 0) -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block 448-bit "abcdbcdecdefdefg...nopq": first = 1, then first = 0 back-to-back at the earliest accept -> final digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1, and the first-block digest pulse observed.
- Hold blk_valid high and toggle blk_data during ROUND -> blk_ready = 0, the block is not re-accepted, and the result is unchanged versus the clean run.
- Assert rst asynchronously at round 30 -> digest = 0 and digest_valid = 0 immediately, IDLE; a following "abc" with first = 1 gives the correct digest.
- "abc" with first = 1, then a second "abc" with first = 1 -> identical digest both times (IV reload, no chaining).
